// File: rtl/btb_lookup_table.sv
// btb_lookup_table: fully-associative branch target buffer with a combinational
// first-taken-slot lookup for a 16-byte fetch group and a registered training port.
module btb_lookup_table #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] lk_pc_i,
   input  logic        upd_en_i,
   input  logic [31:0] upd_pc_i,
   input  logic [31:0] upd_target_i,
   input  logic [2:0]  upd_type_i,
   input  logic        upd_kill_i,
   input  logic        inv_all_i,
   output logic        next_able_o,
   output logic [1:0]  hit_ban_o,
   output logic [31:0] next_pc_o,
   output logic [2:0]  next_type_o
);
   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [27:0]        tag_q    [ENTRIES];
   logic [1:0]         slot_q   [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [2:0]         type_q   [ENTRIES];
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   match_idx, free_idx, wr_idx;
   logic               match, free, wr_en;
   logic               unused_pc_bits;

   assign unused_pc_bits = ^{lk_pc_i[1:0], upd_pc_i[1:0]};

   // Scanning downward with <= lets the lowest index win a slot tie.
   always_comb begin
      next_able_o = 1'b0;
      hit_ban_o   = 2'd0;
      next_pc_o   = 32'd0;
      next_type_o = 3'd0;
      for (int i = ENTRIES - 1; i >= 0; i--)
         if (valid_q[i] && tag_q[i] == lk_pc_i[31:4] && slot_q[i] >= lk_pc_i[3:2] &&
             (!next_able_o || slot_q[i] <= hit_ban_o)) begin
            next_able_o = 1'b1;
            hit_ban_o   = slot_q[i];
            next_pc_o   = target_q[i];
            next_type_o = type_q[i];
         end
   end

   always_comb begin
      match     = 1'b0;
      match_idx = '0;
      free      = 1'b0;
      free_idx  = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (valid_q[i] && tag_q[i] == upd_pc_i[31:4] && slot_q[i] == upd_pc_i[3:2]) begin
            match     = 1'b1;
            match_idx = IDX_W'(i);
         end
         if (!valid_q[i]) begin
            free     = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      valid_d  = valid_q;
      rr_ptr_d = rr_ptr_q;
      wr_en    = 1'b0;
      wr_idx   = match ? match_idx : free ? free_idx : rr_ptr_q;
      if (inv_all_i)
         valid_d = '0;
      else if (upd_en_i && upd_kill_i) begin
         if (match) valid_d[match_idx] = 1'b0;
      end else if (upd_en_i) begin
         wr_en           = 1'b1;
         valid_d[wr_idx] = 1'b1;
         rr_ptr_d        = (match || free) ? rr_ptr_q : rr_ptr_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         valid_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         valid_q  <= valid_d;
         rr_ptr_q <= rr_ptr_d;
      end

   // Payload needs no reset; an entry is meaningless until its valid bit is set.
   always_ff @(posedge clk_i)
      if (wr_en && !rst_i) begin
         tag_q[wr_idx]    <= upd_pc_i[31:4];
         slot_q[wr_idx]   <= upd_pc_i[3:2];
         target_q[wr_idx] <= upd_target_i;
         type_q[wr_idx]   <= upd_type_i;
      end
endmodule

// File: tb/tb_btb_lookup_table.sv
// tb_btb_lookup_table: directed and random checks of the BTB against an
// entry-list reference model with explicit allocation and round-robin rules.
module tb_btb_lookup_table;
   localparam int ENT = 16;
   logic        clk, rst;
   logic [31:0] lk_pc, upd_pc, upd_target;
   logic        upd_en, upd_kill, inv_all;
   logic [2:0]  upd_type;
   logic        able;
   logic [1:0]  ban;
   logic [31:0] npc;
   logic [2:0]  ntype;
   int          vectors = 0;
   int          errs = 0;

   bit          mv  [ENT];
   logic [31:0] mpc [ENT];
   logic [31:0] mtg [ENT];
   logic [2:0]  mty [ENT];
   int          mrr;
   logic [31:0] seen[$];

   btb_lookup_table #(.ENTRIES(16), .IDX_W(4)) dut (
      .clk_i(clk), .rst_i(rst), .lk_pc_i(lk_pc), .upd_en_i(upd_en), .upd_pc_i(upd_pc),
      .upd_target_i(upd_target), .upd_type_i(upd_type), .upd_kill_i(upd_kill),
      .inv_all_i(inv_all), .next_able_o(able), .hit_ban_o(ban), .next_pc_o(npc),
      .next_type_o(ntype)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic logic [37:0] m_look(input logic [31:0] pc);
      int best = 4;
      logic [37:0] r = '0;
      for (int i = 0; i < ENT; i++)
         if (mv[i] && mpc[i][31:4] == pc[31:4] && int'(mpc[i][3:2]) >= int'(pc[3:2]) &&
             int'(mpc[i][3:2]) < best) begin
            best = int'(mpc[i][3:2]);
            r = {1'b1, mpc[i][3:2], mtg[i], mty[i]};
         end
      return r;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < ENT; i++) mv[i] = 0;
      mrr = 0;
   endfunction

   function automatic void m_update(input bit en, input logic [31:0] pc, input logic [31:0] tg,
                                    input logic [2:0] ty, input bit kill, input bit inv);
      int hit = -1;
      int fr = -1;
      int w;
      if (inv) begin
         for (int i = 0; i < ENT; i++) mv[i] = 0;
         return;
      end
      if (!en) return;
      for (int i = ENT - 1; i >= 0; i--) begin
         if (mv[i] && mpc[i][31:2] == pc[31:2]) hit = i;
         if (!mv[i]) fr = i;
      end
      if (kill) begin
         if (hit >= 0) mv[hit] = 0;
         return;
      end
      if (hit >= 0) w = hit;
      else if (fr >= 0) w = fr;
      else begin
         w = mrr;
         mrr = (mrr + 1) % ENT;
      end
      mv[w] = 1; mpc[w] = {pc[31:2], 2'b00}; mtg[w] = tg; mty[w] = ty;
   endfunction

   task automatic chk(input string tag, input logic [37:0] exp);
      vectors++;
      assert ({able, ban, npc, ntype} === exp)
      else begin
         errs++;
         $error("FAIL %s lk_pc=%h observed=%h expected=%h", tag, lk_pc, {able, ban, npc, ntype}, exp);
      end
   endtask

   task automatic look(input logic [31:0] pc, input string tag);
      @(negedge clk);
      lk_pc = pc;
      #1 chk(tag, m_look(pc));
   endtask

   // Drive a lookup and an update together; the lookup must see pre-edge contents.
   task automatic step(input logic [31:0] lk, input bit en, input logic [31:0] pc,
                       input logic [31:0] tg, input logic [2:0] ty, input bit kill,
                       input bit inv, input string tag);
      @(negedge clk);
      lk_pc = lk; upd_en = en; upd_pc = pc; upd_target = tg; upd_type = ty;
      upd_kill = kill; inv_all = inv;
      #1 chk(tag, m_look(lk));
      @(posedge clk);
      #1 m_update(en, pc, tg, ty, kill, inv);
      upd_en = 0; upd_kill = 0; inv_all = 0;
      if (en && !kill && !inv) seen.push_back(pc);
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tg, input logic [2:0] ty);
      step(pc, 1, pc, tg, ty, 0, 0, "upd_pre");
   endtask

   task automatic sweep(input string tag);
      foreach (seen[k]) look({seen[k][31:4], 4'h0}, tag);
   endtask

   initial begin
      rst = 1; lk_pc = 32'h1C00_0000; upd_en = 0; upd_pc = 0; upd_target = 0;
      upd_type = 0; upd_kill = 0; inv_all = 0;
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 chk("reset_out", 38'd0);
      rst = 0;
      look(32'h1C00_0000, "post_reset_a");
      look(32'hFFFF_FFFC, "post_reset_b");
      chk("post_reset_zero", 38'd0);

      upd(32'h1C00_0008, 32'h1C00_0100, 3'd3);
      look(32'h1C00_0000, "slot2_hit");
      chk("slot2_const", {1'b1, 2'd2, 32'h1C00_0100, 3'd3});
      look(32'h1C00_000C, "start_after_slot");
      chk("start_after_const", 38'd0);

      upd(32'h1C00_0004, 32'h1C00_0200, 3'd1);
      look(32'h1C00_0000, "first_taken");
      chk("first_taken_const", {1'b1, 2'd1, 32'h1C00_0200, 3'd1});
      look(32'h1C00_0008, "start_slot2");
      chk("start_slot2_const", {1'b1, 2'd2, 32'h1C00_0100, 3'd3});

      upd(32'h1C00_0008, 32'h1C00_0300, 3'd5);
      look(32'h1C00_0008, "rewrite");
      chk("rewrite_const", {1'b1, 2'd2, 32'h1C00_0300, 3'd5});
      step(32'h1C00_0008, 1, 32'h1C00_0008, 0, 0, 1, 0, "kill_pre");
      look(32'h1C00_0008, "killed");
      chk("killed_const", 38'd0);

      for (int k = 0; k < 15; k++) upd(32'h2000_0000 + k * 16 + 4, 32'h4000_0000 + k, 3'(k));
      sweep("full");
      for (int k = 0; k < 3; k++) upd(32'h2100_0000 + k * 16, 32'h5000_0000 + k, 3'(k));
      sweep("evict3");
      look(32'h1C00_0000, "evicted_slot1");
      chk("evicted_slot1_const", 38'd0);
      for (int k = 3; k < 17; k++) upd(32'h2100_0000 + k * 16, 32'h5000_0000 + k, 3'(k));
      sweep("wrap");

      step(32'h2100_0100, 1, 32'h2200_0000, 32'h1234_5678, 3'd7, 0, 1, "invall_pre");
      void'(seen.pop_back());
      seen.push_back(32'h2200_0000);
      sweep("invall");

      for (int n = 0; n < 300; n++) begin
         logic [31:0] base, pc, lk;
         int r = $urandom_range(0, 99);
         base = (r < 60) ? 32'h1C00_0000 + 32'($urandom_range(0, 3)) * 16
                         : 32'h3000_0000 + 32'($urandom_range(0, 40)) * 16;
         pc = base | 32'($urandom_range(0, 15));
         lk = (seen.size() > 0 && $urandom_range(0, 1) == 1) ?
              seen[$urandom_range(0, seen.size() - 1)] : pc;
         lk = {lk[31:4], 4'($urandom_range(0, 15))};
         step(lk, $urandom_range(0, 3) != 0, pc, $urandom, 3'($urandom),
              $urandom_range(0, 5) == 0, $urandom_range(0, 40) == 0, "rand");
      end
      sweep("rand_sweep");

      upd(32'h1C00_0000, 32'hAAAA_0000, 3'd2);
      @(negedge clk);
      lk_pc = 32'h1C00_0000; upd_en = 1; upd_pc = 32'h1C00_0004;
      upd_target = 32'hBBBB_0000; upd_type = 3'd4;
      #1 rst = 1;
      #1 chk("async_reset", 38'd0);
      m_reset();
      @(posedge clk);
      #1 upd_en = 0;
      @(negedge clk) rst = 0;
      look(32'h1C00_0000, "after_reset_a");
      look(32'h1C00_0004, "after_reset_b");
      chk("after_reset_const", 38'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
